// File: rtl/fifo_serializer_pkg.sv
// ============================================================================
// Module  : ser_pkg
// Brief   : Shared types and constants for the FIFO group serializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ser_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_PAR_READ   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2
    } ser_state_t;

    // Index width for a group of par words; never narrower than one bit.
    function automatic int idx_width(input int par);
        return (par > 1) ? $clog2(par) : 1;
    endfunction

    localparam int DEFAULT_IDX_W = idx_width(DEFAULT_PAR_READ);

endpackage

`default_nettype wire

// File: rtl/fifo_serializer.sv
// ============================================================================
// Module  : fifo_serializer
// Brief   : Pulls PAR_READ-word groups from a FIFO and emits them one word per
//           valid/ready handshake, lowest index first.
//           Optional macro FIFO_SERIALIZER_LAST_EN adds the out_last port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_serializer
    import ser_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PAR_READ   = DEFAULT_PAR_READ
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [PAR_READ-1:0][DATA_WIDTH-1:0]  fifo_data,
    input  logic                                 fifo_valid,
    input  logic                                 fifo_empty,
    output logic                                 fifo_read_enable,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy
`ifdef FIFO_SERIALIZER_LAST_EN
   ,output logic                                 out_last
`endif
);

    localparam int                 IDX_W    = idx_width(PAR_READ);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(PAR_READ - 1);

    ser_state_t                            state_q, state_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic [PAR_READ-1:0][DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                                  handshake;
    logic                                  at_last;

    assign handshake = (state_q == SHIFT) && out_ready;
    assign at_last   = (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = WAIT;
            end
            WAIT: begin
                if (fifo_valid) begin
                    hold_d  = fifo_data;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (handshake) begin
                    if (!at_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (!fifo_empty) begin
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reads are issued only from IDLE or on the final handshake, each followed
    // by WAIT, so two consecutive read pulses cannot occur.
    always_comb begin
        out_valid        = (state_q == SHIFT);
        out_data         = hold_q[idx_q];
        busy             = (state_q != IDLE);
        fifo_read_enable = !rst && !fifo_empty &&
                           ((state_q == IDLE) || (handshake && at_last));
`ifdef FIFO_SERIALIZER_LAST_EN
        out_last         = (state_q == SHIFT) && at_last;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_serializer.sv
`default_nettype none

module tb_fifo_serializer;
    import ser_pkg::*;

    localparam int DW = 8;
    localparam int PR = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [PR-1:0][DW-1:0]   fifo_data;
    logic                    fifo_valid;
    logic                    fifo_empty;
    logic                    fifo_read_enable;
    logic [DW-1:0]           out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;
`ifdef FIFO_SERIALIZER_LAST_EN
    logic                    out_last;
`endif

    always #5 clk = ~clk;

    fifo_serializer #(.DATA_WIDTH(DW), .PAR_READ(PR)) dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_data        (fifo_data),
        .fifo_valid       (fifo_valid),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .busy             (busy)
`ifdef FIFO_SERIALIZER_LAST_EN
       ,.out_last         (out_last)
`endif
    );

    int               checks   = 0;
    int               failures = 0;
    logic [DW-1:0]    exp_q[$];
    logic [PR*DW-1:0] fifo_q[$];
    int               pos      = 0;
    int               rd_count = 0;
    int               rd_before;
    logic             prev_rd    = 1'b0;
    logic             prev_stall = 1'b0;
    logic [DW-1:0]    prev_data  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic load_group(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                              input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        fifo_q.push_back({w3, w2, w1, w0});
        exp_q.push_back(w0);
        exp_q.push_back(w1);
        exp_q.push_back(w2);
        exp_q.push_back(w3);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || !fifo_empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
    endtask

    task automatic wait_out_valid(input string name, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, out_valid}, 32'd1);
    endtask

    // FIFO model: one-cycle read latency, data presented just after the read edge.
    initial begin
        fifo_valid = 1'b0;
        fifo_data  = '0;
        forever begin
            logic rd, rs;
            @(posedge clk);
            rd = fifo_read_enable;
            rs = rst;
            #1;
            if (rd && !rs && fifo_q.size() > 0) begin
                fifo_data  = fifo_q.pop_front();
                fifo_valid = 1'b1;
            end else begin
                fifo_valid = 1'b0;
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Monitor: scores every handshake against the expected-word queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_rd    = 1'b0;
            end else begin
                if (fifo_read_enable) begin
                    rd_count++;
                    check("read_not_back_to_back", {31'd0, prev_rd}, 32'd0);
                end
`ifdef FIFO_SERIALIZER_LAST_EN
                check("out_last", {31'd0, out_last}, {31'd0, out_valid && pos == PR-1});
`endif
                if (out_valid) begin
                    if (prev_stall)
                        check("stall_data_stable", {24'd0, out_data}, {24'd0, prev_data});
                    check("read_at_group_end", {31'd0, fifo_read_enable},
                          {31'd0, out_ready && pos == PR-1 && !fifo_empty});
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_word: got %0h expected none", out_data);
                        end else begin
                            check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                        end
                        pos = (pos + 1) % PR;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_rd    = fifo_read_enable;
            end
        end
    end

    initial begin
        logic pat [7];
        int   n;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset with a group already waiting in the FIFO.
        rst       = 1'b1;
        out_ready = 1'b1;
        load_group(8'hAA, 8'hFF, 8'h00, 8'h55);
        rd_before = rd_count;
        repeat (2) begin
            @(negedge clk);
            check("rst_read_enable", {31'd0, fifo_read_enable}, 32'd0);
            check("rst_out_valid",   {31'd0, out_valid},        32'd0);
            check("rst_busy",        {31'd0, busy},             32'd0);
        end
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single group, downstream always ready: four back-to-back words.
        wait_out_valid("t2_out_valid_seen", 10);
        for (int i = 0; i < PR; i++) begin
            check("t2_valid_run", {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        check("t2_valid_after_group", {31'd0, out_valid}, 32'd0);
        check("t2_idle_after_group",  {31'd0, busy},      32'd0);
        wait_done("t2_drain", 20);
        check("t2_read_count", rd_count - rd_before, 32'd1);

        // Same group with a stalling consumer.
        @(posedge clk); #1;
        out_ready = 1'b0;
        load_group(8'hAA, 8'hFF, 8'h00, 8'h55);
        wait_out_valid("t3_out_valid_seen", 10);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            out_ready = pat[i];
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done("t3_drain", 20);

        // Two queued groups: second read issued on the handshake of the last word.
        @(posedge clk); #1;
        rd_before = rd_count;
        load_group(8'h11, 8'h22, 8'h33, 8'h44);
        load_group(8'h99, 8'h88, 8'h77, 8'h66);
        wait_done("t4_drain", 60);
        check("t4_read_count", rd_count - rd_before, 32'd2);

        // Reset in the middle of a group while idx is 2.
        @(posedge clk); #1;
        load_group(8'h12, 8'h34, 8'h56, 8'h78);
        n = 0;
        while (pos != 2 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_reached_idx2", pos, 32'd2);
        rst       = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_valid_dropped", {31'd0, out_valid}, 32'd0);
        check("t5_busy_dropped",  {31'd0, busy},      32'd0);
        exp_q.delete();
        pos = 0;
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        rd_before = rd_count;
        repeat (10) @(negedge clk);
        check("t5_no_reads_when_empty", rd_count - rd_before, 32'd0);
        check("t5_stays_idle",          {31'd0, busy},        32'd0);
        check("t5_no_valid",            {31'd0, out_valid},   32'd0);

        // Group used to mark the end-of-group word.
        @(posedge clk); #1;
        load_group(8'h01, 8'h02, 8'h03, 8'h04);
        wait_done("t6_drain", 20);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
